// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - serial-in / byte-FIFO-out signal bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic          rx_i;
  logic          pop_i;
  logic          clr_err_i;
  logic [7:0]    data_out_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   count_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          parity_err_o;

  modport master (
    output rx_i, pop_i, clr_err_i,
    input  data_out_o, empty_o, full_o, count_o, frame_err_o, overrun_o, parity_err_o
  );

  modport slave (
    input  rx_i, pop_i, clr_err_i,
    output data_out_o, empty_o, full_o, count_o, frame_err_o, overrun_o, parity_err_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver feeding a first-word-fall-through byte FIFO
// UART_RX_PARITY_EN selects an 8E1 frame with a sticky parity_err; default build is 8N1.
module uart_rx_fifo #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic          rx_meta_q, rx_sync_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_e        state_q, state_d;
  logic [3:0]    s_q, s_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_sample, push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d, parity_set, parity_err_q, parity_err_d;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic          empty, full, do_push, do_pop;

  // Tick counter is held at zero while idle so sampling phases line up with the start edge.
  always_comb begin
    tick = (tick_cnt_q == TW'(DIV - 1));
    if (state_q == S_IDLE || tick) tick_cnt_d = '0;
    else                           tick_cnt_d = tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      s_q        <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= bus.rx_i;
      rx_sync_q  <= rx_meta_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      s_q        <= s_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        s_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: if (tick) begin
        if (s_q == 4'd7) begin
          s_d     = '0;
          idx_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      S_DATA: if (tick) begin
        s_d = s_q + 4'd1;
        if (s_q == 4'd15) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) begin
        s_d = s_q + 4'd1;
        if (s_q == 4'd15) begin
          par_bad_d = ((^shift_q) != rx_sync_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: if (tick) begin
        s_d = s_q + 4'd1;
        // Leaving at mid-stop-bit lets the next start edge be caught without a gap.
        if (s_q == 4'd15) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stop_sample = (state_q == S_STOP) && tick && (s_q == 4'd15);
    frame_set   = stop_sample && !rx_sync_q;
`ifdef UART_RX_PARITY_EN
    push_req    = stop_sample && rx_sync_q && !par_bad_q;
    parity_set  = (state_q == S_PARITY) && tick && (s_q == 4'd15) && ((^shift_q) != rx_sync_q);
`else
    push_req    = stop_sample && rx_sync_q;
`endif
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = bus.pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign do_push = push_req && (!full || do_pop);

  always_comb begin
    wr_ptr_d    = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
    frame_err_d = frame_set || (frame_err_q && !bus.clr_err_i);
    overrun_d   = (push_req && full && !do_pop) || (overrun_q && !bus.clr_err_i);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_set || (parity_err_q && !bus.clr_err_i);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.data_out_o  = empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.count_o     = count_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_o = parity_err_q;
`else
  assign bus.parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (DIV=10, 160 clk/bit, DEPTH=4)
module tb_uart_rx_fifo;
  localparam int DEPTH   = 4;
  localparam int BIT_CLK = 160;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(10_000), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 1523;
  logic [7:0] model_q[$];
  logic m_ferr = 1'b0;
  logic m_ovr  = 1'b0;

  // Stop bit is sampled at 9.5 bit times after the start edge, plus synchroniser delay.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle);
    bus.rx_i = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    bus.rx_i = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  task automatic pulse_pop;
    bus.pop_i = 1'b1;
    @(negedge clk);
    bus.pop_i = 1'b0;
  endtask

  task automatic pulse_clr;
    bus.clr_err_i = 1'b1;
    @(negedge clk);
    bus.clr_err_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.rx_i = 1'b1; bus.pop_i = 1'b0; bus.clr_err_i = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", bus.empty_o); end
    vectors++; if (bus.full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", bus.full_o); end
    vectors++; if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    vectors++; if (bus.data_out_o !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", bus.data_out_o); end
    vectors++; if ({bus.frame_err_o, bus.overrun_o, bus.parity_err_o} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {bus.frame_err_o, bus.overrun_o, bus.parity_err_o}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_release_empty got %b want 1", bus.empty_o); end
  endtask

  task automatic test_single;
    int got = -1;
    fork
      send_frame(8'hA5, 1'b1, 200);
      begin
        for (int n = 1; n <= 2000; n++) begin
          @(negedge clk);
          if (!bus.empty_o) begin got = n; break; end
        end
      end
    join
    vectors++;
    if (got < 1521 || got > 1526) begin
      miscompares++; $display("FAIL single_latency got %0d want 1521..1526", got);
    end else begin
      lat = got;
    end
    vectors++; if (bus.count_o !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", bus.count_o); end
    vectors++; if (bus.data_out_o !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", bus.data_out_o); end
    pulse_pop();
    vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL single_pop_empty got %b want 1", bus.empty_o); end
  endtask

  task automatic test_glitch;
    logic [7:0] b;
    bus.rx_i = 1'b0;
    repeat (50) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (400) @(negedge clk);
    vectors++; if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL glitch_count got %0d want 0", bus.count_o); end
    vectors++; if ({bus.frame_err_o, bus.overrun_o} !== 2'b00) begin miscompares++; $display("FAIL glitch_flags got %b want 00", {bus.frame_err_o, bus.overrun_o}); end
    b = 8'($urandom);
    send_frame(b, 1'b1, 200);
    vectors++; if (bus.data_out_o !== b || bus.count_o !== 3'd1) begin miscompares++; $display("FAIL glitch_next_byte got %h/%0d want %h/1", bus.data_out_o, bus.count_o, b); end
    pulse_pop();
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 200);
    vectors++; if (bus.frame_err_o !== 1'b1) begin miscompares++; $display("FAIL ferr_flag got %b want 1", bus.frame_err_o); end
    vectors++; if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL ferr_count got %0d want 0", bus.count_o); end
    pulse_clr();
    vectors++; if (bus.frame_err_o !== 1'b0) begin miscompares++; $display("FAIL ferr_clear got %b want 0", bus.frame_err_o); end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (i == 5) ? 200 : 0);
    vectors++; if (bus.full_o !== 1'b1 || bus.count_o !== 3'd4) begin miscompares++; $display("FAIL b2b_full got full=%b count=%0d want 1/4", bus.full_o, bus.count_o); end
    vectors++; if (bus.overrun_o !== 1'b1) begin miscompares++; $display("FAIL b2b_overrun got %b want 1", bus.overrun_o); end
    vectors++; if (bus.frame_err_o !== 1'b0) begin miscompares++; $display("FAIL b2b_frame_err got %b want 0", bus.frame_err_o); end
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (bus.data_out_o !== 8'(i)) begin miscompares++; $display("FAIL b2b_pop%0d got %h want %h", i, bus.data_out_o, 8'(i)); end
      pulse_pop();
    end
    vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL b2b_drained got %b want 1", bus.empty_o); end
    pulse_clr();
    vectors++; if (bus.overrun_o !== 1'b0) begin miscompares++; $display("FAIL b2b_ovr_clear got %b want 0", bus.overrun_o); end
  endtask

  task automatic test_push_pop_full;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, (i == 3) ? 100 : 0);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1, 200);
      begin
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        bus.pop_i = 1'b1;
        @(negedge clk);
        bus.pop_i = 1'b0;
      end
    join
    vectors++; if (bus.count_o !== 3'd4) begin miscompares++; $display("FAIL pp_count got %0d want 4", bus.count_o); end
    vectors++; if (bus.overrun_o !== 1'b0) begin miscompares++; $display("FAIL pp_overrun got %b want 0", bus.overrun_o); end
    foreach (exp_q[i]) begin
      vectors++; if (bus.data_out_o !== exp_q[i]) begin miscompares++; $display("FAIL pp_pop%0d got %h want %h", i, bus.data_out_o, exp_q[i]); end
      pulse_pop();
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic stop;
    int npop;
    pulse_clr();
    model_q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    for (int f = 0; f < 8; f++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop, 40);
      if (!stop) m_ferr = 1'b1;
      else if (model_q.size() == DEPTH) m_ovr = 1'b1;
      else model_q.push_back(b);
      vectors++; if (bus.count_o !== 3'(model_q.size())) begin miscompares++; $display("FAIL rnd%0d_count got %0d want %0d", f, bus.count_o, model_q.size()); end
      vectors++; if ({bus.frame_err_o, bus.overrun_o} !== {m_ferr, m_ovr}) begin miscompares++; $display("FAIL rnd%0d_flags got %b want %b", f, {bus.frame_err_o, bus.overrun_o}, {m_ferr, m_ovr}); end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (model_q.size() != 0) begin
          vectors++; if (bus.data_out_o !== model_q[0]) begin miscompares++; $display("FAIL rnd%0d_head got %h want %h", f, bus.data_out_o, model_q[0]); end
          void'(model_q.pop_front());
        end
        pulse_pop();
      end
      vectors++; if (bus.empty_o !== (model_q.size() == 0)) begin miscompares++; $display("FAIL rnd%0d_empty got %b want %b", f, bus.empty_o, model_q.size() == 0); end
    end
    while (bus.empty_o === 1'b0 && model_q.size() != 0) begin
      void'(model_q.pop_front());
      pulse_pop();
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    send_frame(8'h5A, 1'b1, 100);
    fork
      send_frame(8'hC3, 1'b1, 200);
      begin
        repeat (700) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.empty_o !== 1'b1 || bus.count_o !== 3'd0 || bus.data_out_o !== 8'h00) begin miscompares++; $display("FAIL midrst_fifo got empty=%b count=%0d data=%h want 1/0/00", bus.empty_o, bus.count_o, bus.data_out_o); end
      end
    join
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL midrst_release got %b want 1", bus.empty_o); end
    b = 8'($urandom);
    send_frame(b, 1'b1, 200);
    vectors++; if (bus.data_out_o !== b || bus.count_o !== 3'd1) begin miscompares++; $display("FAIL midrst_next got %h/%0d want %h/1", bus.data_out_o, bus.count_o, b); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_push_pop_full();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
